// File: rtl/axi_fc_controller.sv
// Streaming FC inference controller: loads one activation vector over AXI4-Stream,
// then evaluates the hidden layers and the output layer one per clock.
module axi_fc_controller #(
    parameter int DATA_WIDTH       = 8,
    parameter int IN_LAYER_WIDTH   = 4,
    parameter int HIDDEN_LAYER_CNT = 1,
    parameter int OUT_LAYER_WIDTH  = 4
) (
    input  logic                                  axi_clk,
    input  logic                                  axi_reset_n,
    input  logic                                  s_axis_valid,
    input  logic [31:0]                           s_axis_data,
    output logic                                  s_axis_ready,
    output logic [DATA_WIDTH*OUT_LAYER_WIDTH-1:0] fc_out,
    output logic                                  fc_fin_valid
);

    // state      | meaning
    // ST_LOAD    | accepting input beats into act[cnt]
    // ST_COMPUTE | one layer per cycle; output layer on layer == HIDDEN_LAYER_CNT
    localparam logic [0:0] ST_LOAD    = 1'b0;
    localparam logic [0:0] ST_COMPUTE = 1'b1;

    localparam int CW = $clog2(IN_LAYER_WIDTH);
    localparam int LW = $clog2(HIDDEN_LAYER_CNT + 2);
    localparam logic [CW-1:0] CNT_LAST   = CW'(IN_LAYER_WIDTH - 1);
    localparam logic [LW-1:0] LAYER_LAST = LW'(HIDDEN_LAYER_CNT);

    logic [0:0]                            state;
    logic [CW-1:0]                         cnt;
    logic [LW-1:0]                         layer;
    logic                                  run_q;
    logic [DATA_WIDTH-1:0]                 act      [IN_LAYER_WIDTH];
    logic [DATA_WIDTH-1:0]                 hid_next [IN_LAYER_WIDTH];
    logic [DATA_WIDTH*OUT_LAYER_WIDTH-1:0] out_next;
    logic                                  beat_ok;

    // Both operands are below 2**DATA_WIDTH, so the extra bit is a clean sign.
    function automatic logic [DATA_WIDTH-1:0] relu_diff(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH:0] d;
        d = {1'b0, a} - {1'b0, b};
        relu_diff = d[DATA_WIDTH] ? '0 : d[DATA_WIDTH-1:0];
    endfunction

    generate
        if (DATA_WIDTH < 32) begin : g_unused
            logic unused_upper;
            assign unused_upper = ^s_axis_data[31:DATA_WIDTH];
        end
    endgenerate

    // run_q keeps ready low until the first edge after reset release.
    assign s_axis_ready = run_q && (state == ST_LOAD);
    assign beat_ok      = s_axis_ready && s_axis_valid;

    always_comb begin
        for (int j = 0; j < IN_LAYER_WIDTH; j++) begin
            hid_next[j] = '0;
        end
        out_next = '0;
        for (int j = 0; j < IN_LAYER_WIDTH; j++) begin
            hid_next[j] = relu_diff(act[j], act[(j + 1) % IN_LAYER_WIDTH]);
        end
        for (int j = 0; j < OUT_LAYER_WIDTH; j++) begin
            out_next[j*DATA_WIDTH +: DATA_WIDTH] =
                relu_diff(act[j % IN_LAYER_WIDTH], act[(j + 1) % IN_LAYER_WIDTH]);
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state        <= ST_LOAD;
            cnt          <= '0;
            layer        <= '0;
            run_q        <= 1'b0;
            fc_out       <= '0;
            fc_fin_valid <= 1'b0;
            for (int i = 0; i < IN_LAYER_WIDTH; i++) begin
                act[i] <= '0;
            end
        end else begin
            run_q        <= 1'b1;
            fc_fin_valid <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (beat_ok) begin
                        act[cnt] <= s_axis_data[DATA_WIDTH-1:0];
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            layer <= '0;
                            state <= ST_COMPUTE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (layer == LAYER_LAST) begin
                        fc_out       <= out_next;
                        fc_fin_valid <= 1'b1;
                        layer        <= '0;
                        state        <= ST_LOAD;
                    end else begin
                        for (int i = 0; i < IN_LAYER_WIDTH; i++) begin
                            act[i] <= hid_next[i];
                        end
                        layer <= layer + 1'b1;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_fc_controller.sv
// Directed bench for axi_fc_controller with DW=4, IN=4, H=1, OUT=4.
module tb_axi_fc_controller;

    logic        axi_clk      = 1'b0;
    logic        axi_reset_n  = 1'b1;
    logic        s_axis_valid = 1'b0;
    logic [31:0] s_axis_data  = 32'h0;
    logic        s_axis_ready;
    logic [15:0] fc_out;
    logic        fc_fin_valid;

    int compared   = 0;
    int mismatched = 0;

    always #5 axi_clk = ~axi_clk;

    axi_fc_controller #(
        .DATA_WIDTH      (4),
        .IN_LAYER_WIDTH  (4),
        .HIDDEN_LAYER_CNT(1),
        .OUT_LAYER_WIDTH (4)
    ) dut (
        .axi_clk     (axi_clk),
        .axi_reset_n (axi_reset_n),
        .s_axis_valid(s_axis_valid),
        .s_axis_data (s_axis_data),
        .s_axis_ready(s_axis_ready),
        .fc_out      (fc_out),
        .fc_fin_valid(fc_fin_valid)
    );

    task automatic test_reset();
        #2 axi_reset_n = 1'b0;
        #1;
        compared++;
        if (fc_out !== 16'h0) begin
            mismatched++;
            $display("FAIL reset_fc_out: got %h expected 0000", fc_out);
        end
        compared++;
        if (fc_fin_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_fin: got %b expected 0", fc_fin_valid);
        end
        compared++;
        if (s_axis_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_ready: got %b expected 0", s_axis_ready);
        end
        repeat (2) @(posedge axi_clk);
        @(negedge axi_clk);
        axi_reset_n = 1'b1;
        #1;
        compared++;
        if (s_axis_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL release_ready_pre_edge: got %b expected 0", s_axis_ready);
        end
        @(posedge axi_clk); #1;
        compared++;
        if (s_axis_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL release_ready_post_edge: got %b expected 1", s_axis_ready);
        end
    endtask

    // Sends one vector (optional gap before beat 2, optional held 9s during
    // COMPUTE) and checks the 2-edge completion timing and result.
    task automatic run_vec(input string name,
                           input logic [31:0] b0, input logic [31:0] b1,
                           input logic [31:0] b2, input logic [31:0] b3,
                           input int gap_len, input bit hold9,
                           input logic [15:0] exp);
        logic [31:0] b [4];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge axi_clk);
                    s_axis_valid = 1'b0;
                    s_axis_data  = 32'h0;
                    @(posedge axi_clk); #1;
                    compared++;
                    if (s_axis_ready !== 1'b1) begin
                        mismatched++;
                        $display("FAIL %s gap_ready: got %b expected 1", name, s_axis_ready);
                    end
                end
            end
            @(negedge axi_clk);
            s_axis_valid = 1'b1;
            s_axis_data  = b[i];
        end
        @(posedge axi_clk); #1;
        compared++;
        if (s_axis_ready !== 1'b0 || fc_fin_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL %s edge_k: ready=%b fin=%b expected ready=0 fin=0",
                     name, s_axis_ready, fc_fin_valid);
        end
        @(negedge axi_clk);
        s_axis_valid = hold9;
        s_axis_data  = 32'h9;
        @(posedge axi_clk); #1;
        compared++;
        if (s_axis_ready !== 1'b0 || fc_fin_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL %s edge_k1: ready=%b fin=%b expected ready=0 fin=0",
                     name, s_axis_ready, fc_fin_valid);
        end
        @(posedge axi_clk); #1;
        compared++;
        if (fc_fin_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL %s fin_pulse: got %b expected 1", name, fc_fin_valid);
        end
        compared++;
        if (fc_out !== exp) begin
            mismatched++;
            $display("FAIL %s fc_out: got %h expected %h", name, fc_out, exp);
        end
        compared++;
        if (s_axis_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL %s ready_on_fin: got %b expected 1", name, s_axis_ready);
        end
        @(negedge axi_clk);
        s_axis_valid = 1'b0;
        s_axis_data  = 32'h0;
        @(posedge axi_clk); #1;
        compared++;
        if (fc_fin_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL %s fin_drop: got %b expected 0", name, fc_fin_valid);
        end
        compared++;
        if (fc_out !== exp) begin
            mismatched++;
            $display("FAIL %s fc_out_hold: got %h expected %h", name, fc_out, exp);
        end
    endtask

    task automatic test_basic();
        run_vec("basic", 32'd0, 32'd1, 32'd0, 32'd2, 0, 1'b0, 16'h2010);
    endtask

    task automatic test_relu();
        run_vec("relu", 32'd5, 32'd3, 32'd7, 32'd1, 0, 1'b0, 16'h0602);
    endtask

    task automatic test_gap();
        run_vec("gap", 32'd0, 32'd1, 32'd0, 32'd2, 3, 1'b0, 16'h2010);
    endtask

    task automatic test_hold_during_compute();
        run_vec("hold9", 32'd0, 32'd1, 32'd0, 32'd2, 0, 1'b1, 16'h2010);
        run_vec("after_hold", 32'd5, 32'd3, 32'd7, 32'd1, 0, 1'b0, 16'h0602);
    endtask

    task automatic test_mask();
        run_vec("mask", 32'hFFFF_FFF3, 32'hFFFF_FFF0, 32'd0, 32'd0, 0, 1'b0, 16'h0003);
    endtask

    task automatic test_back_to_back();
        logic [31:0] v [4];
        v[0] = 32'd0; v[1] = 32'd1; v[2] = 32'd0; v[3] = 32'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge axi_clk);
            s_axis_valid = 1'b1;
            s_axis_data  = v[i];
        end
        @(posedge axi_clk);
        @(negedge axi_clk);
        s_axis_valid = 1'b0;
        repeat (2) @(posedge axi_clk);
        #1;
        compared++;
        if (fc_fin_valid !== 1'b1 || fc_out !== 16'h2010) begin
            mismatched++;
            $display("FAIL b2b_first: fin=%b fc_out=%h expected fin=1 fc_out=2010",
                     fc_fin_valid, fc_out);
        end
        v[0] = 32'd5; v[1] = 32'd3; v[2] = 32'd7; v[3] = 32'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge axi_clk);
            s_axis_valid = 1'b1;
            s_axis_data  = v[i];
            @(posedge axi_clk); #1;
            if (i == 0) begin
                compared++;
                if (fc_fin_valid !== 1'b0 || fc_out !== 16'h2010) begin
                    mismatched++;
                    $display("FAIL b2b_hold_during_load: fin=%b fc_out=%h expected fin=0 fc_out=2010",
                             fc_fin_valid, fc_out);
                end
            end
        end
        @(negedge axi_clk);
        s_axis_valid = 1'b0;
        repeat (2) @(posedge axi_clk);
        #1;
        compared++;
        if (fc_fin_valid !== 1'b1 || fc_out !== 16'h0602) begin
            mismatched++;
            $display("FAIL b2b_second: fin=%b fc_out=%h expected fin=1 fc_out=0602",
                     fc_fin_valid, fc_out);
        end
        @(posedge axi_clk); #1;
        compared++;
        if (fc_fin_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_fin_drop: got %b expected 0", fc_fin_valid);
        end
    endtask

    task automatic test_reset_mid_stream();
        @(negedge axi_clk);
        s_axis_valid = 1'b1;
        s_axis_data  = 32'd5;
        @(negedge axi_clk);
        s_axis_data  = 32'd3;
        @(negedge axi_clk);
        s_axis_valid = 1'b0;
        s_axis_data  = 32'd0;
        axi_reset_n  = 1'b0;
        #1;
        compared++;
        if (fc_out !== 16'h0 || fc_fin_valid !== 1'b0 || s_axis_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_reset_clear: fc_out=%h fin=%b ready=%b expected 0000/0/0",
                     fc_out, fc_fin_valid, s_axis_ready);
        end
        @(posedge axi_clk); #1;
        compared++;
        if (s_axis_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_reset_ready_held: got %b expected 0", s_axis_ready);
        end
        @(negedge axi_clk);
        axi_reset_n = 1'b1;
        @(posedge axi_clk); #1;
        compared++;
        if (s_axis_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_reset_ready_back: got %b expected 1", s_axis_ready);
        end
        run_vec("post_reset", 32'd0, 32'd1, 32'd0, 32'd2, 0, 1'b0, 16'h2010);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_gap();
        test_hold_during_compute();
        test_mask();
        test_back_to_back();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/axi_fc_controller.md
# axi_fc_controller

Streaming fully-connected (FC) inference controller for the RTL CNN non-linear stage. It accepts one input-layer vector of `IN_LAYER_WIDTH` unsigned activations over an AXI4-Stream slave. It then evaluates `HIDDEN_LAYER_CNT` hidden layers plus one output layer, one layer per clock, using fixed difference weights and ReLU. It presents the packed output-layer vector with a one-cycle completion strobe.

## Interface
- `DATA_WIDTH`, default 8: bits per activation; unsigned.
- `IN_LAYER_WIDTH`, default 4: input-layer and hidden-layer neuron count (≥2).
- `HIDDEN_LAYER_CNT`, default 1: number of hidden layers (≥0).
- `OUT_LAYER_WIDTH`, default 4: output-layer neuron count (≥1).

Ports:
- `axi_clk` in 1: single clock; all logic on the rising edge.
- `axi_reset_n` in 1: reset, asynchronous, active-low.
- `s_axis_valid` in 1: input beat valid.
- `s_axis_data` in 32: input beat; bits `[DATA_WIDTH-1:0]` hold one activation, upper bits are ignored.
- `s_axis_ready` out 1: block can accept a beat.
- `fc_out` out `DATA_WIDTH*OUT_LAYER_WIDTH`: output neuron j is at `[j*DATA_WIDTH +: DATA_WIDTH]`.
- `fc_fin_valid` out 1: one-cycle pulse; `fc_out` has just been updated with a new result.

## Operation
- States: LOAD, COMPUTE.
- **LOAD**
  - `s_axis_ready`=1.
  - A beat is accepted on a rising edge with `s_axis_valid`=1. It is stored as `x[cnt]`, and then `cnt` increments.
  - Beats arrive in order x0 first. Gaps (valid=0) pause loading with no timeout.
  - On acceptance of beat `IN_LAYER_WIDTH-1`: `cnt`←0, layer index←0, go to COMPUTE.
- **COMPUTE**
  - `s_axis_ready`=0; any `s_axis_valid` is ignored and no data is consumed.
  - Each cycle evaluates one layer from the current vector `a` (width W=`IN_LAYER_WIDTH`).
  - Neuron j of a hidden layer: `y_j = ReLU(a[j] − a[(j+1) mod W])`.
  - Neuron j of the output layer: `y_j = ReLU(a[j mod W] − a[(j+1) mod W])`.
  - Width rule: the subtraction is done in `DATA_WIDTH+1`-bit signed. A negative result becomes 0; a non-negative result fits `DATA_WIDTH` unsigned exactly. There is no overflow and no saturation logic is needed.
  - Hidden results overwrite `a` in place.
  - Evaluation order: `HIDDEN_LAYER_CNT` hidden layers, then the output layer. That is `HIDDEN_LAYER_CNT+1` cycles total.
  - On the output-layer cycle: register `fc_out`, assert `fc_fin_valid` next cycle, return to LOAD.
- `fc_out` holds its last result until the next completion. It is not cleared on a new load.
- Evaluation reads only registered activations; no new input affects an in-flight computation.

## Timing
- Reset values: `fc_out`=0, `fc_fin_valid`=0, `s_axis_ready`=0 while `axi_reset_n`=0. State=LOAD, `cnt`=0, activation registers=0.
- `s_axis_ready` is 1 from the first edge after reset deassertion, i.e. it is decoded from the registered state.
- Latency: the last beat is accepted at edge k. Layers are evaluated at edges k+1 … k+H+1 (H=`HIDDEN_LAYER_CNT`). `fc_out` and `fc_fin_valid` go high after edge k+H+1. `fc_fin_valid` drops after edge k+H+2.
- `s_axis_ready` returns to 1 in the same cycle `fc_fin_valid` is high, so back-to-back vectors are allowed. Throughput is one vector per `IN_LAYER_WIDTH+H+1` cycles.
- Reset mid-load or mid-compute: the partial vector and layer progress are discarded. Outputs take their reset values immediately, without waiting for a clock edge.

## Test plan
- DW=4, IN=4, H=1, OUT=4: reset, then beats 0,1,0,2 on consecutive cycles.
  - Required response: `fc_out`=0x2010.
  - `fc_fin_valid` is high for exactly one cycle, 2 edges after the last beat.
  - `s_axis_ready`=0 for those 2 cycles.
- Same config, beats 5,3,7,1 → hidden vector 2,0,6,0 → `fc_out`=0x0602 (ReLU clamping exercised).
- Valid gaps: beats 0,1 then valid=0 for 3 cycles, then 0,2 → same 0x2010. The completion time shifts by the gap.
- Beats offered with valid=1 during COMPUTE: 0,1,0,2 followed by 9,9 held.
  - The 9s are not accepted while ready=0.
  - After completion the next vector loads from beats accepted in LOAD only.
- Upper-bit masking: beat 0xFFFFFFF3 → treated as 3.
- Reset mid-stream: after 2 beats, pulse `axi_reset_n` low, then send a full vector 0,1,0,2.
  - Outputs clear during reset.
  - Result is 0x2010 with no contamination from the partial vector.
